// File: rtl/writeback_queue_if.sv
// Bundles the writeback queue's source handshakes, register-file write port,
// forwarding lookups and occupancy flags.
interface writeback_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          a_valid;
  logic [4:0]    a_reg;
  logic [31:0]   a_data;
  logic          a_ready;
  logic          b_valid;
  logic [4:0]    b_reg;
  logic [31:0]   b_data;
  logic          b_ready;
  logic          write_stall;
  logic          write_en;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic [4:0]    lookup_address1;
  logic [4:0]    lookup_address2;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [31:0]   fwd_data1;
  logic [31:0]   fwd_data2;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  // master: the pipeline around the queue (sources, regfile, operand lookup)
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output write_stall, lookup_address1, lookup_address2,
    input  a_ready, b_ready, write_en, write_reg, write_data,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, full, empty
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  write_stall, lookup_address1, lookup_address2,
    output a_ready, b_ready, write_en, write_reg, write_data,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, full, empty
  );
endinterface

// File: rtl/writeback_queue.sv
// Two-source writeback FIFO in front of a single register-file write port,
// with round-robin arbitration on the last free slot and operand forwarding.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_queue_if.slave wb
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW:0] ONE_W   = (CW + 1)'(1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_grant_q, last_grant_d;   // 1: A won the last contention

  logic [4:0]    reg_mem_q  [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic [CW:0]   free;
  logic          pop;
  logic          contended;
  logic          a_wins;
  logic          push_a;
  logic          push_b;
  logic [PW-1:0] tail_b;

  assign wb.empty = (count_q == '0);
  assign wb.full  = (count_q == CW'(DEPTH));
  assign wb.count = count_q;

  assign pop           = !wb.empty && !wb.write_stall;
  assign wb.write_en   = pop;
  assign wb.write_reg  = pop ? reg_mem_q[head_q]  : 5'd0;
  assign wb.write_data = pop ? data_mem_q[head_q] : 32'd0;

  // The slot freed by this cycle's pop is reusable in the same cycle.
  assign free = DEPTH_W - {1'b0, count_q} + {{CW{1'b0}}, pop};

  assign a_wins    = !last_grant_q;
  assign contended = wb.a_valid && wb.b_valid && (free == ONE_W);

  assign wb.a_ready = (free != '0) && !(wb.b_valid && (free == ONE_W) && !a_wins);
  assign wb.b_ready = (free != '0) && !(wb.a_valid && (free == ONE_W) && a_wins);

  // Register 0 results complete the handshake but are never stored.
  assign push_a = wb.a_valid && wb.a_ready && (wb.a_reg != 5'd0);
  assign push_b = wb.b_valid && wb.b_ready && (wb.b_reg != 5'd0);
  assign tail_b = tail_q + PW'(push_a);

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q + PW'(push_a) + PW'(push_b);
    count_d      = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    last_grant_d = last_grant_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (contended) begin
      last_grant_d = a_wins;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_a) begin
      reg_mem_q[tail_q]  <= wb.a_reg;
      data_mem_q[tail_q] <= wb.a_data;
    end
    if (push_b) begin
      reg_mem_q[tail_b]  <= wb.b_reg;
      data_mem_q[tail_b] <= wb.b_data;
    end
  end

  logic [4:0] lk_addr [2];
  assign lk_addr[0] = wb.lookup_address1;
  assign lk_addr[1] = wb.lookup_address2;

  // Scan oldest to youngest so the last match seen is the youngest one.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_fwd
    logic        hit_c;
    logic [31:0] data_c;
    always_comb begin
      logic [PW-1:0] idx;
      hit_c  = 1'b0;
      data_c = 32'd0;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if ((CW'(i) < count_q) && (lk_addr[gi] != 5'd0) && (reg_mem_q[idx] == lk_addr[gi])) begin
          hit_c  = 1'b1;
          data_c = data_mem_q[idx];
        end
      end
    end
  end

  assign wb.fwd_hit1  = g_fwd[0].hit_c;
  assign wb.fwd_data1 = g_fwd[0].data_c;
  assign wb.fwd_hit2  = g_fwd[1].hit_c;
  assign wb.fwd_data2 = g_fwd[1].data_c;

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port a_valid  input  1  source A (ALU) has a result to retire.
REQ-005 SHALL have port a_reg  input  5  destination register for source A.
REQ-006 SHALL have port a_data  input  32  result data for source A.
REQ-007 SHALL have port a_ready  output  1  source A result is accepted this cycle.
REQ-008 SHALL have ports b_valid, b_reg, b_data and b_ready, with the same widths and meanings as the A ports, for source B (load/multiply).
REQ-009 SHALL have port write_stall  input  1  register-file write port unavailable this cycle.
REQ-010 SHALL have port write_en  output  1  drives the register-file write enable.
REQ-011 SHALL have port write_reg  output  5  drives the register-file write address.
REQ-012 SHALL have port write_data  output  32  drives the register-file write data.
REQ-013 SHALL have ports lookup_address1 and lookup_address2  input  5  each  forwarding lookup addresses.
REQ-014 SHALL have ports fwd_hit1 and fwd_hit2  output  1  each  a pending entry matches the lookup address.
REQ-015 SHALL have ports fwd_data1 and fwd_data2  output  32  each  forwarded data.
REQ-016 SHALL have port count  output  clog2(DEPTH+1)  number of valid entries; also full (count==DEPTH) and empty (count==0), each output 1.

Function
REQ-017 SHALL be a circular FIFO of {reg, data} entries using a head pointer, a tail pointer and a count register; the pointers wrap modulo DEPTH.
REQ-018 SHALL present the head entry combinationally: write_en = !empty && !write_stall; write_reg and write_data SHALL be the head fields when write_en=1 and 0 otherwise.
REQ-019 SHALL pop the head on each clock edge where write_en=1.
REQ-020 SHALL compute free = DEPTH - count + (write_en ? 1 : 0) every cycle.
REQ-021 SHALL accept both sources in the same cycle when both are valid and free>=2; A is enqueued first (older), then B.
REQ-022 SHALL, when both sources are valid and free==1, accept only the round-robin winner: the source not granted at the last contended cycle.
REQ-023 SHALL update the last_grant register only on contended cycles with free==1; after reset, A wins the first contention.
REQ-024 SHALL assert ready for a single valid source whenever free>=1.
REQ-025 SHALL deassert a ready whenever free==0 or the source loses arbitration.
REQ-026 SHALL make ready independent of that source's own valid, except through arbitration.
REQ-027 SHALL treat a handshake as valid&&ready.
REQ-028 SHALL complete the handshake for an accepted entry with reg==0 without storing it; the slot is freed and count is unchanged by that entry.
REQ-029 SHALL satisfy, in a simultaneous push and pop cycle, next count = count + pushes - pop; count SHALL never exceed DEPTH and never underflow.
REQ-030 SHALL set fwd_hitN=1 iff lookup_addressN!=0 and some stored entry, including the head being written this cycle, has reg==lookup_addressN.
REQ-031 SHALL drive fwd_dataN with the youngest matching entry's data, or 0 when there is no hit.
REQ-032 SHALL NOT forward entries still being enqueued in the current cycle.
REQ-033 SHALL exhibit a latency of one cycle from acceptance to appearance at the head when the queue is empty and not stalled.

Reset
REQ-034 SHALL, on rst_n low, immediately clear head, tail, count and last_grant; storage contents need not be cleared.
REQ-035 SHALL, during and after reset, hold write_en=0, write_reg=0, write_data=0, fwd_hit*=0, fwd_data*=0, count=0, empty=1 and full=0.
REQ-036 SHALL, when reset occurs mid-operation, discard all pending entries with no register-file write occurring.
REQ-037 SHALL, with both sources valid, assert a_ready=b_ready=1 on the first cycle after rst_n rises.

Verification
REQ-038 Single write: A pushes reg 3 with 0x1234 -> next cycle write_en=1, write_reg=3, write_data=0x1234; then empty=1.
REQ-039 Dual push: A and B both valid with free>=2 -> both accepted; A's entry is written one cycle before B's.
REQ-040 Fill under stall: write_stall=1 and 4 pushes -> full=1, count=4, a_ready=b_ready=0; deassert stall -> one pop per cycle in FIFO order.
REQ-041 Contention at free==1: A wins the first contention, B the next, alternating while both stay valid.
REQ-042 Forwarding: entries reg 5=0xA then reg 5=0xB queued, lookup_address1=5 -> fwd_hit1=1, fwd_data1=0xB; lookup_address1=0 -> fwd_hit1=0.
REQ-043 Reg-0 drop and reset: a reg 0 push is accepted with count unchanged and no write; asserting rst_n low with 3 entries queued -> count=0, write_en=0 asynchronously.
